// File: rtl/axis_sweep_controller_if.sv
// axis_sweep_controller_if: sweep configuration, control strobes and generator/status outputs
interface axis_sweep_controller_if #(
    parameter int PHASE_WIDTH = 30,
    parameter int CNTR_WIDTH  = 32
);
    logic [PHASE_WIDTH-1:0] cfg_start;
    logic [PHASE_WIDTH-1:0] cfg_step;
    logic [CNTR_WIDTH-1:0]  cfg_steps;
    logic [CNTR_WIDTH-1:0]  cfg_dwell;
    logic                   cfg_repeat;
    logic                   trg;
    logic                   abort;
    logic                   smp_en;
    logic                   gen_resetn;
    logic [PHASE_WIDTH-1:0] phase_inc;
    logic                   busy;
    logic                   done;
    logic [CNTR_WIDTH-1:0]  sts_step;

    modport master (
        input  cfg_start, cfg_step, cfg_steps, cfg_dwell, cfg_repeat, trg, abort, smp_en,
        output gen_resetn, phase_inc, busy, done, sts_step
    );

    modport slave (
        output cfg_start, cfg_step, cfg_steps, cfg_dwell, cfg_repeat, trg, abort, smp_en,
        input  gen_resetn, phase_inc, busy, done, sts_step
    );
endinterface

// File: rtl/axis_sweep_controller.sv
// axis_sweep_controller: steps the phase generator increment through a latched frequency sweep
module axis_sweep_controller #(
    parameter int PHASE_WIDTH = 30,
    parameter int CNTR_WIDTH  = 32
) (
    input logic                     aclk,
    input logic                     aresetn,
    axis_sweep_controller_if.master sw
);
    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    localparam logic [CNTR_WIDTH-1:0] ONE = CNTR_WIDTH'(1);

    state_t                 state_q, state_d;
    logic                   trg_q;
    logic [PHASE_WIDTH-1:0] start_q, start_d;
    logic [PHASE_WIDTH-1:0] delta_q, delta_d;
    logic [CNTR_WIDTH-1:0]  steps_max_q, steps_max_d;
    logic [CNTR_WIDTH-1:0]  dwell_max_q, dwell_max_d;
    logic                   repeat_q, repeat_d;
    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [CNTR_WIDTH-1:0]  step_q, step_d;
    logic [CNTR_WIDTH-1:0]  dwell_q, dwell_d;
    logic                   gen_resetn_q, gen_resetn_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   trg_edge;
    logic                   dwell_end;

    assign trg_edge  = sw.trg & ~trg_q;
    assign dwell_end = sw.smp_en && (dwell_q == dwell_max_q - ONE);

    assign sw.gen_resetn = gen_resetn_q;
    assign sw.phase_inc  = phase_q;
    assign sw.busy       = busy_q;
    assign sw.done       = done_q;
    assign sw.sts_step   = step_q;

    // Next-state and registered-output logic; abort overrides every state transition
    always_comb begin
        state_d      = state_q;
        start_d      = start_q;
        delta_d      = delta_q;
        steps_max_d  = steps_max_q;
        dwell_max_d  = dwell_max_q;
        repeat_d     = repeat_q;
        phase_d      = phase_q;
        step_d       = step_q;
        dwell_d      = dwell_q;
        gen_resetn_d = gen_resetn_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        if (sw.abort) begin
            state_d      = IDLE;
            gen_resetn_d = 1'b0;
            busy_d       = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trg_edge) begin
                        state_d      = ARM;
                        start_d      = sw.cfg_start;
                        delta_d      = sw.cfg_step;
                        steps_max_d  = (sw.cfg_steps == '0) ? ONE : sw.cfg_steps;
                        dwell_max_d  = (sw.cfg_dwell == '0) ? ONE : sw.cfg_dwell;
                        repeat_d     = sw.cfg_repeat;
                        phase_d      = sw.cfg_start;
                        step_d       = '0;
                        dwell_d      = '0;
                        gen_resetn_d = 1'b0;
                        busy_d       = 1'b1;
                    end
                end
                ARM: begin
                    state_d      = RUN;
                    gen_resetn_d = 1'b1;
                end
                RUN: begin
                    if (sw.smp_en) begin
                        dwell_d = dwell_end ? '0 : dwell_q + ONE;
                        if (dwell_end) begin
                            if (step_q < steps_max_q - ONE) begin
                                step_d  = step_q + ONE;
                                phase_d = phase_q + delta_q;
                            end else if (repeat_q) begin
                                step_d  = '0;
                                phase_d = start_q;
                            end else begin
                                state_d = DONE;
                                done_d  = 1'b1;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, shadow and output registers with asynchronous active-low reset
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            trg_q        <= 1'b0;
            start_q      <= '0;
            delta_q      <= '0;
            steps_max_q  <= '0;
            dwell_max_q  <= '0;
            repeat_q     <= 1'b0;
            phase_q      <= '0;
            step_q       <= '0;
            dwell_q      <= '0;
            gen_resetn_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            trg_q        <= sw.trg;
            start_q      <= start_d;
            delta_q      <= delta_d;
            steps_max_q  <= steps_max_d;
            dwell_max_q  <= dwell_max_d;
            repeat_q     <= repeat_d;
            phase_q      <= phase_d;
            step_q       <= step_d;
            dwell_q      <= dwell_d;
            gen_resetn_q <= gen_resetn_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end
endmodule

// File: tb/tb_axis_sweep_controller.sv
// tb_axis_sweep_controller: scoreboard bench for the sweep controller
module tb_axis_sweep_controller;
    typedef struct {
        logic        smp;
        logic [64:0] exp;
    } ent_t;

    logic aclk;
    logic aresetn;
    int   checks = 0;
    int   errors = 0;
    ent_t sb[$];
    ent_t e;

    axis_sweep_controller_if #(.PHASE_WIDTH(30), .CNTR_WIDTH(32)) ifc ();

    axis_sweep_controller #(.PHASE_WIDTH(30), .CNTR_WIDTH(32)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .sw      (ifc)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [64:0] obs();
        return {ifc.gen_resetn, ifc.busy, ifc.done, ifc.phase_inc, ifc.sts_step};
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Expected {gen_resetn,busy,done,phase_inc,sts_step} per cycle from ARM through the cycle after DONE
    task automatic plan_sweep(input logic [29:0] start, input logic [29:0] step,
                              input int s_max, input int d_max, input int p);
        logic [29:0] ph;
        ph = start;
        sb.push_back('{1'b0, {3'b010, start, 32'd0}});
        for (int s = 0; s < s_max; s++) begin
            for (int j = 0; j < d_max * p; j++)
                sb.push_back('{((j + 1) % p) == 0, {3'b110, ph, 32'(s)}});
            if (s < s_max - 1) ph = ph + step;
        end
        sb.push_back('{1'b0, {3'b101, ph, 32'(s_max - 1)}});
        sb.push_back('{1'b0, {3'b100, ph, 32'(s_max - 1)}});
    endtask

    task automatic fire(input logic [29:0] start, input logic [29:0] step, input logic [31:0] steps,
                        input logic [31:0] dwell, input logic rep, input logic hold);
        ifc.cfg_start  = start;
        ifc.cfg_step   = step;
        ifc.cfg_steps  = steps;
        ifc.cfg_dwell  = dwell;
        ifc.cfg_repeat = rep;
        ifc.trg        = 1'b1;
        tick();
        ifc.trg        = hold;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        ifc.cfg_start = '0; ifc.cfg_step = '0; ifc.cfg_steps = '0; ifc.cfg_dwell = '0;
        ifc.cfg_repeat = 1'b0; ifc.trg = 1'b0; ifc.abort = 1'b0; ifc.smp_en = 1'b0;
        #12;
        checks++;
        if (obs() !== 65'd0) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", obs(), 65'd0);
        end
        aresetn = 1'b1;
        tick();
        checks++;
        if (obs() !== 65'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h expected %h", obs(), 65'd0);
        end
    endtask

    task automatic test_basic();
        plan_sweep(30'd1000, 30'd500, 3, 4, 1);
        fire(30'd1000, 30'd500, 32'd3, 32'd4, 1'b0, 1'b0);
        ifc.cfg_start = 30'd77; ifc.cfg_step = 30'd9; ifc.cfg_steps = 32'd1; ifc.cfg_dwell = 32'd2;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (obs() !== e.exp) begin
                errors++;
                $display("FAIL basic_sweep: got %h expected %h", obs(), e.exp);
            end
            ifc.smp_en = e.smp;
            tick();
        end
        ifc.smp_en = 1'b1;
        tick();
        checks++;
        if (obs() !== {3'b100, 30'd2000, 32'd2}) begin
            errors++;
            $display("FAIL basic_hold_tone: got %h expected %h", obs(), {3'b100, 30'd2000, 32'd2});
        end
        ifc.smp_en = 1'b0;
    endtask

    task automatic test_throttled();
        plan_sweep(30'd1000, 30'd500, 3, 4, 3);
        fire(30'd1000, 30'd500, 32'd3, 32'd4, 1'b0, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (obs() !== e.exp) begin
                errors++;
                $display("FAIL throttled: got %h expected %h", obs(), e.exp);
            end
            ifc.smp_en = e.smp;
            tick();
        end
        ifc.smp_en = 1'b0;
    endtask

    task automatic test_wrap();
        logic [29:0] starts [2];
        logic [29:0] steps  [2];
        int          counts [2];
        starts[0] = 30'h3FFF_FF9C; steps[0] = 30'd200;      counts[0] = 2;
        starts[1] = 30'd1000;      steps[1] = 30'h3FFF_FF06; counts[1] = 3;
        for (int c = 0; c < 2; c++) begin
            plan_sweep(starts[c], steps[c], counts[c], 2, 1);
            fire(starts[c], steps[c], 32'(counts[c]), 32'd2, 1'b0, 1'b0);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (obs() !== e.exp) begin
                    errors++;
                    $display("FAIL wrap_%0d: got %h expected %h", c, obs(), e.exp);
                end
                ifc.smp_en = e.smp;
                tick();
            end
            ifc.smp_en = 1'b0;
        end
    endtask

    task automatic test_repeat_abort();
        sb.push_back('{1'b1, {3'b010, 30'd5000, 32'd0}});
        for (int k = 0; k < 10; k++)
            sb.push_back('{1'b1, {3'b110, (k % 2 == 1) ? 30'd5300 : 30'd5000, 32'(k % 2)}});
        fire(30'd5000, 30'd300, 32'd2, 32'd1, 1'b1, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (obs() !== e.exp) begin
                errors++;
                $display("FAIL repeat: got %h expected %h", obs(), e.exp);
            end
            ifc.smp_en = e.smp;
            tick();
        end
        ifc.abort = 1'b1;
        tick();
        checks++;
        if (obs() !== {3'b000, 30'd5000, 32'd0}) begin
            errors++;
            $display("FAIL abort_run: got %h expected %h", obs(), {3'b000, 30'd5000, 32'd0});
        end
        ifc.smp_en = 1'b0;
        ifc.trg = 1'b1;
        tick();
        checks++;
        if (obs() !== {3'b000, 30'd5000, 32'd0}) begin
            errors++;
            $display("FAIL abort_trg_idle: got %h expected %h", obs(), {3'b000, 30'd5000, 32'd0});
        end
        ifc.abort = 1'b0;
        tick();
        checks++;
        if (obs() !== {3'b000, 30'd5000, 32'd0}) begin
            errors++;
            $display("FAIL abort_no_late_edge: got %h expected %h", obs(), {3'b000, 30'd5000, 32'd0});
        end
        ifc.trg = 1'b0;
        tick();
    endtask

    task automatic test_edge_cases();
        plan_sweep(30'd42, 30'd7, 1, 1, 1);
        fire(30'd42, 30'd7, 32'd0, 32'd0, 1'b0, 1'b1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (obs() !== e.exp) begin
                errors++;
                $display("FAIL zero_cfg: got %h expected %h", obs(), e.exp);
            end
            ifc.smp_en = e.smp;
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ifc.busy !== 1'b0) begin
                errors++;
                $display("FAIL trg_held_once: busy got %b expected 0", ifc.busy);
            end
            tick();
        end
        ifc.trg = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        fire(30'd7, 30'd1, 32'd5, 32'd10, 1'b0, 1'b0);
        ifc.smp_en = 1'b1;
        repeat (3) tick();
        checks++;
        if (obs() !== {3'b110, 30'd7, 32'd0}) begin
            errors++;
            $display("FAIL pre_reset_run: got %h expected %h", obs(), {3'b110, 30'd7, 32'd0});
        end
        #2 aresetn = 1'b0;
        #1;
        checks++;
        if (obs() !== 65'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", obs(), 65'd0);
        end
        #2 aresetn = 1'b1;
        tick();
        checks++;
        if (obs() !== 65'd0) begin
            errors++;
            $display("FAIL after_async_reset: got %h expected %h", obs(), 65'd0);
        end
        ifc.smp_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_throttled();
        test_wrap();
        test_repeat_abort();
        test_edge_cases();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_sweep_controller.md
# axis_sweep_controller

Sequencer that drives the phase-increment input of the AXI-Stream phase generator to produce stepped frequency sweeps. It latches a sweep description (start increment, signed step, step count, dwell), holds the generator in reset for one cycle at sweep start, then advances the increment after each dwell, counted in accepted generator samples. It sits between the configuration register bank and the phase generator's `cfg_data` and reset inputs, and reports busy, done and the current step index back to the register bank.

## Interface
- `PHASE_WIDTH`, 30: width of the phase increment; must equal the generator's `PHASE_WIDTH`.
- `CNTR_WIDTH`, 32: width of the step-count, dwell and status counters.

- `aclk`  in  1  clock.
- `aresetn`  in  1  reset, asynchronous assert, active-low.
- `cfg_start`  in  PHASE_WIDTH  first phase increment of the sweep.
- `cfg_step`  in  PHASE_WIDTH  two's-complement increment delta per step.
- `cfg_steps`  in  CNTR_WIDTH  number of frequency steps per sweep; 0 is treated as 1.
- `cfg_dwell`  in  CNTR_WIDTH  accepted samples per step; 0 is treated as 1.
- `cfg_repeat`  in  1  0 = single sweep, 1 = restart the sweep continuously.
- `trg`  in  1  start request; rising edge, level-sampled on `aclk`.
- `abort`  in  1  synchronous stop request; level-sensitive.
- `smp_en`  in  1  generator `m_axis_tvalid & m_axis_tready`.
- `gen_resetn`  out  1  drives the generator's `aresetn`.
- `phase_inc`  out  PHASE_WIDTH  drives the generator's `cfg_data`.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse at the end of a single sweep.
- `sts_step`  out  CNTR_WIDTH  current step index, 0-based.

## Operation
- Reset values: `gen_resetn`=0, `phase_inc`=0, `busy`=0, `done`=0, `sts_step`=0, state IDLE, `trg` history register=0, all shadow registers=0.
- All outputs are registered.
- Reset is asynchronous: asserting `aresetn` mid-sweep forces the reset values immediately.
- States are IDLE, ARM, RUN and DONE.
- **IDLE**
  - A `trg` rising edge (current sample 1, previous sample 0) moves to ARM.
  - On that transition, latch `cfg_start`, `cfg_step`, max(`cfg_steps`,1), max(`cfg_dwell`,1) and `cfg_repeat` into shadow registers.
  - Config changes after the latch have no effect until the next trigger.
- **ARM** (exactly 1 cycle)
  - `gen_resetn`=0, `phase_inc`=start, `busy`=1, step counter=0, dwell counter=0.
  - Next state is RUN.
- **RUN**
  - `gen_resetn`=1, `busy`=1.
  - The dwell counter increments on `smp_en` only.
  - When `smp_en` is high and dwell = dwell_max-1, the dwell counter clears and:
    - if step < steps_max-1: step increments and `phase_inc` += step, modulo 2^PHASE_WIDTH;
    - else if repeat: `phase_inc`=start, step=0, and the generator is not reset;
    - else: move to DONE.
- **DONE** (exactly 1 cycle)
  - `done`=1, `busy`=0.
  - Next state is IDLE.
- After DONE, `phase_inc` holds the final increment and `gen_resetn` stays 1, so the last tone keeps playing.
- A new trigger restarts from ARM.
- `abort`=1 in any state moves to IDLE next cycle, with `gen_resetn`=0, `busy`=0, `done`=0 and `phase_inc` held.
- `abort` wins over a simultaneous `trg` edge and over a simultaneous step or sweep end.
- A `trg` edge during ARM, RUN or DONE is ignored. The edge detector still tracks `trg` in those states, so a level held high through DONE does not retrigger.
- `sts_step` mirrors the step counter and is cleared in ARM.

## Timing
- `trg` first sampled high at cycle N: in N+1 the block is in ARM with `busy`=1, `gen_resetn`=0 and `phase_inc`=start.
- In N+2 the block is in RUN with `gen_resetn`=1.
- `smp_en` is ignored outside RUN.
- The `smp_en` that completes a dwell at cycle M gives the new `phase_inc` and `sts_step` at M+1, or DONE at M+1.
- The generator consumes the new `cfg_data` on its next accepted sample.
- In a single sweep with `smp_en` held at 1 throughout RUN:
  - RUN lasts steps_max·dwell_max cycles;
  - `done` is high at cycle N+2+steps_max·dwell_max.
- `abort` high at cycle K: IDLE with `gen_resetn`=0 and `busy`=0 at K+1.

## Test plan
- **Basic sweep:** start=1000, step=500, steps=3, dwell=4, no repeat, `smp_en`=1 → `phase_inc` 1000×4, 1500×4, 2000×4 cycles in RUN; `done` pulse; `phase_inc` stays 2000 and `gen_resetn` stays 1.
- **Throttled samples:** same config with `smp_en` high every 3rd cycle → each step lasts 12 cycles; `sts_step` reads 0,1,2.
- **Wrap and negative step:**
  - start=2^30-100, step=200, steps=2 → second increment is 100;
  - start=1000, step=2^30-250, steps=3 → 1000, 750, 500.
- **Repeat mode:** steps=2, dwell=1, repeat=1 → `phase_inc` alternates start, start+step indefinitely; `gen_resetn` stays 1 and `done` never pulses.
- **Abort:** `abort` mid-RUN → `busy`=0 and `gen_resetn`=0 next cycle; `trg`+`abort` together in IDLE → stays in IDLE.
- **Edge cases:**
  - steps=0, dwell=0 → one step of one sample, then `done`;
  - `aresetn` asserted mid-RUN → all outputs at reset values immediately;
  - `trg` held high → exactly one sweep.
